// File: rtl/me_bank_pkg.sv
// me_bank_pkg: constants and FSM state shared by the reference-window bank reader and writer
package me_bank_pkg;
    localparam int PIXEL      = 8;
    localparam int WORD_W     = 8 * PIXEL;
    localparam int SEG_ROWS   = 24;
    localparam int NUM_SEGS   = 4;
    localparam int BANK_DEPTH = SEG_ROWS * NUM_SEGS;
    localparam int ADDR_W     = 7;
    localparam int ROW_W      = 5;
    localparam int BANK_W     = 3;
    localparam int SEG_W      = $clog2(NUM_SEGS);
    localparam int CRED_W     = $clog2(NUM_SEGS + 1);
    localparam int BEAT_W     = WORD_W + BANK_W + ROW_W + 1;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
endpackage

// File: rtl/ref_skid_fifo2.sv
// ref_skid_fifo2: 2-entry FIFO of captured beats {data, bank, row, last}; head drives the stream
module ref_skid_fifo2
    import me_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [BEAT_W-1:0] din,
    output logic [BEAT_W-1:0] dout,
    output logic [1:0]        count
);
    logic [BEAT_W-1:0] mem_q [2];
    logic [BEAT_W-1:0] mem_d [2];
    logic       wp_q, wp_d, rp_q, rp_d;
    logic [1:0] cnt_q, cnt_d;
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q + 2'(push) - 2'(pop);
        if (push) begin
            mem_d[wp_q] = din;
            wp_d        = ~wp_q;
        end
        if (pop) rp_d = ~rp_q;
        if (clr) begin
            wp_d  = 1'b0;
            rp_d  = 1'b0;
            cnt_d = 2'd0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    assign dout  = mem_q[rp_q];
    assign count = cnt_q;
endmodule

// File: rtl/ref_bank_reader.sv
// ref_bank_reader: reads completed segments row-major across all banks into a valid/ready stream
module ref_bank_reader
    import me_bank_pkg::*;
#(
    parameter int NUM_BANKS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        rd_enable,
    input  logic                        wr_seg_done,
    output logic                        seg_free,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [NUM_BANKS-1:0]        mem_cen_n,
    input  logic [NUM_BANKS*WORD_W-1:0] mem_q,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W-1:0]           out_data,
    output logic [2:0]                  out_bank,
    output logic [4:0]                  out_row,
    output logic                        out_last,
    output logic                        ovf_err
);
    state_t            state_q, state_d;
    logic [CRED_W-1:0] credit_q, credit_d;
    logic [SEG_W-1:0]  seg_ptr_q, seg_ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ROW_W-1:0]  row_q, row_d, cap_row_q, cap_row_d;
    logic [BANK_W-1:0] bank_q, bank_d, cap_bank_q, cap_bank_d;
    logic              inflight_q, inflight_d, cap_last_q, cap_last_d;
    logic              seg_free_q, seg_free_d, ovf_q, ovf_d;
    logic [1:0]        fifo_count;
    logic [BEAT_W-1:0] head;
    logic              pop, issue, last_pos, bank_end, done, wr_ok;
    assign pop      = out_valid && out_ready;
    assign bank_end = bank_q == BANK_W'(NUM_BANKS - 1);
    assign last_pos = bank_end && row_q == ROW_W'(SEG_ROWS - 1);
    // a beat popped this cycle frees its slot, which keeps 1 beat/clk with two buffer entries
    assign issue    = state_q == READ && rd_enable && !flush
                      && (int'(fifo_count) - int'(pop) + int'(inflight_q)) < 2;
    assign done     = state_q == DRAIN && inflight_q && cap_last_q;
    assign wr_ok    = wr_seg_done && (credit_q != CRED_W'(NUM_SEGS) || seg_free_q);
    assign mem_addr  = base_q + ADDR_W'(row_q);
    assign mem_cen_n = ~(NUM_BANKS'(issue) << bank_q);
    always_comb begin
        credit_d   = credit_q + CRED_W'(wr_ok) - CRED_W'(seg_free_q);
        ovf_d      = ovf_q || (wr_seg_done && !wr_ok);
        seg_ptr_d  = seg_ptr_q;
        base_d     = base_q;
        row_d      = row_q;
        bank_d     = bank_q;
        inflight_d = issue;
        cap_bank_d = bank_q;
        cap_row_d  = row_q;
        cap_last_d = last_pos;
        seg_free_d = done;
        // credit drops only at the end of the seg_free cycle, so IDLE must not restart before then
        state_d    = (state_q == IDLE && credit_q != '0 && !seg_free_q) ? READ
                   : (state_q == READ && issue && last_pos) ? DRAIN
                   : done ? IDLE : state_q;
        if (issue && !last_pos) begin
            bank_d = bank_end ? '0 : bank_q + 1'b1;
            row_d  = bank_end ? row_q + 1'b1 : row_q;
        end
        if (done) begin
            row_d     = '0;
            bank_d    = '0;
            seg_ptr_d = (seg_ptr_q == SEG_W'(NUM_SEGS - 1)) ? '0 : seg_ptr_q + 1'b1;
            base_d    = (seg_ptr_q == SEG_W'(NUM_SEGS - 1)) ? '0 : base_q + ADDR_W'(SEG_ROWS);
        end
        if (flush) begin
            state_d    = IDLE;
            credit_d   = '0;
            seg_ptr_d  = '0;
            base_d     = '0;
            row_d      = '0;
            bank_d     = '0;
            inflight_d = 1'b0;
            seg_free_d = 1'b0;
            ovf_d      = ovf_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            seg_ptr_q  <= '0;
            base_q     <= '0;
            row_q      <= '0;
            bank_q     <= '0;
            inflight_q <= 1'b0;
            cap_bank_q <= '0;
            cap_row_q  <= '0;
            cap_last_q <= 1'b0;
            seg_free_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            seg_ptr_q  <= seg_ptr_d;
            base_q     <= base_d;
            row_q      <= row_d;
            bank_q     <= bank_d;
            inflight_q <= inflight_d;
            cap_bank_q <= cap_bank_d;
            cap_row_q  <= cap_row_d;
            cap_last_q <= cap_last_d;
            seg_free_q <= seg_free_d;
            ovf_q      <= ovf_d;
        end
    end
    ref_skid_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (inflight_q),
        .pop   (pop),
        .din   ({mem_q[int'(cap_bank_q)*WORD_W +: WORD_W], cap_bank_q, cap_row_q, cap_last_q}),
        .dout  (head),
        .count (fifo_count)
    );
    assign out_valid = fifo_count != 2'd0;
    assign {out_data, out_bank, out_row, out_last} = head;
    assign seg_free  = seg_free_q;
    assign ovf_err   = ovf_q;
endmodule

// File: tb/tb_ref_bank_reader.sv
// tb_ref_bank_reader: checks the bank reader against a segment-level model of bank contents
module tb_ref_bank_reader;
    localparam int NB = 4;
    localparam int SR = 24;
    localparam int NS = 4;
    logic            clk = 0;
    logic            rst_n = 0;
    logic            flush = 0, rd_enable = 1, wr_seg_done = 0, out_ready = 1;
    logic            seg_free, out_valid, out_last, ovf_err;
    logic [6:0]      mem_addr;
    logic [NB-1:0]   mem_cen_n;
    logic [NB*64-1:0] mem_q = '0;
    logic [63:0]     out_data;
    logic [2:0]      out_bank;
    logic [4:0]      out_row;
    ref_bank_reader #(.NUM_BANKS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rd_enable(rd_enable),
        .wr_seg_done(wr_seg_done), .seg_free(seg_free), .mem_addr(mem_addr),
        .mem_cen_n(mem_cen_n), .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_bank(out_bank), .out_row(out_row), .out_last(out_last),
        .ovf_err(ovf_err)
    );
    always #5 clk = ~clk;
    logic [63:0] bank_mem [NB][SR*NS];
    always @(posedge clk)
        for (int b = 0; b < NB; b++)
            if (!mem_cen_n[b]) mem_q[b*64 +: 64] <= bank_mem[b][mem_addr];
    typedef struct {
        logic [3:0] pat;
        int pause_at;
        int pause_len;
        int exp_base;
        int exp_span;
        int exp_frees;
    } vec_t;
    vec_t vecs [5];
    logic [72:0] exp_q [$];
    int iss_q [$];
    int n_cmp = 0, n_bad = 0, cyc = 0, n_free = 0;
    int issued = 0, delivered = 0, seg_issued = 0, seg_del = 0, first_addr = -1;
    int first_cyc = 0, last_cyc = 0, m_ptr = 0, m_credit = 0;
    bit m_ovf = 0, prev_stall = 0;
    logic [72:0] prev_word;
    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic step();
        logic [72:0] w, e;
        int ib, ie;
        @(negedge clk);
        cyc++;
        w = {out_data, out_bank, out_row, out_last};
        chk($countones(~mem_cen_n) <= 1, "cen_onehot", mem_cen_n, 0);
        if (!rd_enable || flush) chk(&mem_cen_n, "cen_idle", mem_cen_n, {NB{1'b1}});
        if (!(&mem_cen_n)) begin
            ib = 0;
            for (int b = 0; b < NB; b++) if (!mem_cen_n[b]) ib = b;
            if (seg_issued == 0) first_addr = int'(mem_addr);
            if (iss_q.size() == 0) chk(0, "unexpected_issue", {mem_addr, 3'(ib)}, 0);
            else begin
                ie = iss_q.pop_front();
                chk(int'(mem_addr) * 8 + ib == ie, "issue_addr_bank", int'(mem_addr) * 8 + ib, ie);
            end
            issued++;
            seg_issued++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk(0, "unexpected_beat", w, 0);
            else begin
                e = exp_q.pop_front();
                chk(w == e, "beat", w, e);
            end
            if (seg_del == 0) first_cyc = cyc;
            if (out_last) begin
                last_cyc = cyc;
                m_credit--;
            end
            seg_del++;
            delivered++;
        end
        chk(issued - delivered <= 2, "outstanding", issued - delivered, 2);
        if (prev_stall) chk(out_valid && w == prev_word, "stall_stable", w, prev_word);
        prev_stall = out_valid && !out_ready && !flush;
        prev_word = w;
        if (seg_free) n_free++;
        @(posedge clk);
        #1;
    endtask
    task automatic write_seg();
        int a;
        if (m_credit == NS) m_ovf = 1;
        else begin
            for (int r = 0; r < SR; r++)
                for (int b = 0; b < NB; b++) begin
                    a = m_ptr * SR + r;
                    exp_q.push_back({bank_mem[b][a], 3'(b), 5'(r), (r == SR - 1 && b == NB - 1)});
                    iss_q.push_back(a * 8 + b);
                end
            m_credit++;
            m_ptr = (m_ptr + 1) % NS;
        end
        wr_seg_done = 1;
        step();
        wr_seg_done = 0;
    endtask
    task automatic run(input logic [3:0] pat, input int pause_at, input int pause_len, input bit rnd);
        int guard = 0, pc = 0;
        seg_issued = 0;
        seg_del = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : pat[guard % 4];
            if (rnd) rd_enable = $urandom_range(0, 4) != 0;
            else if (pause_at >= 0 && seg_issued == pause_at && pc < pause_len) begin
                rd_enable = 0;
                pc++;
            end else rd_enable = 1;
            step();
            guard++;
        end
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
        out_ready = 1;
        rd_enable = 1;
        repeat (4) step();
    endtask
    task automatic model_clear();
        exp_q.delete();
        iss_q.delete();
        m_ptr = 0;
        m_credit = 0;
        issued = 0;
        delivered = 0;
        seg_issued = 0;
        prev_stall = 0;
    endtask
    initial begin
        int f0, g, nseg;
        vecs[0] = '{4'b1111, -1, 0, 0, 95, 1};
        vecs[1] = '{4'b1001, -1, 0, 24, -1, 1};
        vecs[2] = '{4'b1111, 42, 7, 48, 102, 1};
        vecs[3] = '{4'b1011, -1, 0, 72, -1, 1};
        vecs[4] = '{4'b1111, -1, 0, 0, 95, 1};
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < SR * NS; a++) bank_mem[b][a] = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        chk({mem_cen_n, mem_addr, out_valid, out_last, seg_free, ovf_err, out_data, out_bank, out_row} ==
            {{NB{1'b1}}, 7'd0, 4'd0, 64'd0, 3'd0, 5'd0}, "reset_state",
            {mem_cen_n, mem_addr, out_valid, out_last, seg_free, ovf_err}, {{NB{1'b1}}, 11'd0});
        rst_n = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            f0 = n_free;
            write_seg();
            run(vecs[i].pat, vecs[i].pause_at, vecs[i].pause_len, 0);
            chk(first_addr == vecs[i].exp_base, "seg_base", first_addr, vecs[i].exp_base);
            chk(n_free - f0 == vecs[i].exp_frees, "seg_free_count", n_free - f0, vecs[i].exp_frees);
            if (vecs[i].exp_span >= 0)
                chk(last_cyc - first_cyc == vecs[i].exp_span, "beat_span", last_cyc - first_cyc, vecs[i].exp_span);
        end
        f0 = n_free;
        write_seg();
        g = 0;
        seg_issued = 0;
        seg_del = 0;
        while (!seg_free && g < 500) begin
            step();
            g++;
        end
        chk(seg_free, "free_seen", seg_free, 1);
        write_seg();
        run(4'b1111, -1, 0, 0);
        chk(n_free - f0 == 2, "coincident_frees", n_free - f0, 2);
        f0 = n_free;
        write_seg();
        g = 0;
        seg_issued = 0;
        while (seg_issued < 20 && g < 500) begin
            step();
            g++;
        end
        flush = 1;
        step();
        flush = 0;
        chk(!out_valid && &mem_cen_n, "flush_quiet", {out_valid, mem_cen_n}, {1'b0, {NB{1'b1}}});
        model_clear();
        repeat (6) step();
        chk(n_free == f0, "flush_no_free", n_free - f0, 0);
        write_seg();
        run(4'b1111, -1, 0, 0);
        chk(first_addr == 0, "post_flush_base", first_addr, 0);
        chk(n_free - f0 == 1, "post_flush_frees", n_free - f0, 1);
        for (int k = 0; k < 3; k++) begin
            f0 = n_free;
            nseg = $urandom_range(1, 3);
            for (int s = 0; s < nseg; s++) write_seg();
            run(4'b1111, -1, 0, 1);
            chk(n_free - f0 == nseg, "rand_frees", n_free - f0, nseg);
        end
        rd_enable = 0;
        for (int s = 0; s < 4; s++) write_seg();
        chk(ovf_err == m_ovf, "no_ovf_at_4", ovf_err, m_ovf);
        write_seg();
        step();
        chk(ovf_err == m_ovf && m_ovf, "ovf_set", ovf_err, 1);
        flush = 1;
        step();
        flush = 0;
        model_clear();
        step();
        chk(ovf_err && !out_valid, "ovf_after_flush", {ovf_err, out_valid}, 2'b10);
        rd_enable = 1;
        rst_n = 0;
        #1;
        chk(!ovf_err && !out_valid && &mem_cen_n && mem_addr == 0, "async_reset",
            {ovf_err, out_valid, mem_cen_n, mem_addr}, {2'b00, {NB{1'b1}}, 7'd0});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ref_bank_reader.md
Name: ref_bank_reader

Overview:
Read-side sequencer for the reference-window bank array. Each bank is a 96x64-bit single-port-read SRAM, split into 4 segments of 24 rows, and the write side fills the segments round-robin. This block waits for a completed segment, then reads it out row-major across all banks. It absorbs the 1-cycle SRAM read latency and presents a 64-bit (8-pixel) valid/ready stream to the ME datapath. When a segment is fully read it hands it back to the writer.

Parameters:
PIXEL, 8, bits per pixel; data word = 8*PIXEL
NUM_BANKS, 4, banks read per row (2..8)
SEG_ROWS, 24, rows per segment
NUM_SEGS, 4, segments per bank; SEG_ROWS*NUM_SEGS <= 2^ADDR_W
ADDR_W, 7, SRAM row address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of all state except ovf_err
rd_enable  in  1  level; permits issuing reads
wr_seg_done  in  1  pulse: writer finished one segment in all banks
seg_free  out  1  pulse: oldest segment fully read, writer may overwrite
mem_addr  out  ADDR_W  shared read address to all banks
mem_cen_n  out  NUM_BANKS  per-bank chip enable, active-low, at most one low
mem_q  in  NUM_BANKS*8*PIXEL  bank outputs, bank b at bits [b*64 +: 64]; valid 1 cycle after its cen_n low
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  8*PIXEL  pixel word
out_bank  out  3  source bank of out_data
out_row  out  5  row within segment, 0..SEG_ROWS-1
out_last  out  1  last beat of segment
ovf_err  out  1  sticky: wr_seg_done while credit==NUM_SEGS

Behaviour:
- Reset: mem_cen_n all 1, mem_addr 0, out_valid/out_last/seg_free/ovf_err 0, out_data/out_bank/out_row 0. State IDLE, credit 0, seg_ptr 0, row 0, bank 0, FIFO empty.
- Credit counter (0..NUM_SEGS) tracks written, unread segments.
  - +1 on wr_seg_done; -1 on seg_free.
  - Both in the same cycle: unchanged.
  - wr_seg_done at NUM_SEGS: credit holds and ovf_err is set.
- Issue order: for row 0..SEG_ROWS-1, bank 0..NUM_BANKS-1. mem_addr = seg_ptr*SEG_ROWS + row.
- Issue condition: state READ && rd_enable && (fifo_count + inflight) < 2.
  - inflight: 1-bit register set on issue, cleared the next cycle when mem_q is captured.
- Capture: the cycle after issue, mem_q slice of the issued bank plus bank/row/last tags are pushed into a 2-entry output FIFO.
  - out_* are driven from the FIFO head; pop on out_valid && out_ready.
  - Throughput is 1 beat/clk with out_ready held high.
  - Read-to-out_valid latency: 2 clk (issue at T, capture at T+1, out_valid registered at T+2).
- Backpressure: with out_ready low, at most 2 beats are buffered and no data is lost. out_data, out_bank, out_row and out_last stay stable while out_valid && !out_ready.
- FSM:
  - IDLE -> READ when credit>0 && !flush.
  - READ -> DRAIN after issuing row SEG_ROWS-1, bank NUM_BANKS-1.
  - DRAIN -> IDLE when the last beat is captured into the FIFO. That cycle: seg_free pulses 1 clk, seg_ptr advances mod NUM_SEGS, row/bank reset to 0.
  - A new segment may start issuing 2 clk after seg_free at the earliest.
- rd_enable low in READ pauses issue at the current row/bank. In-flight data still lands; resume continues the sequence exactly.
- seg_ptr wraps 3->0. Address wraps 95->0 with it.
- flush (any state):
  - next cycle: state IDLE; credit, seg_ptr, row, bank, inflight and FIFO cleared; out_valid 0; mem_cen_n all 1.
  - no seg_free is generated.
  - wr_seg_done in the flush cycle is ignored.
- Async reset mid-segment behaves as flush plus clearing ovf_err.
- Widths: out_bank and out_row are zero-extended from internal counters. Address multiply is done by an incrementing base register (+SEG_ROWS per segment), with no multiplier.

Decomposition:
- Shared package me_bank_pkg: PIXEL, SEG_ROWS, NUM_SEGS, BANK_DEPTH=96, ADDR_W, the word-width localparam, and the FSM state enum {IDLE, READ, DRAIN}. The writer-side bank uses the same constants.
- One sub-module: ref_skid_fifo2, a 2-entry FIFO carrying {data, bank, row, last} with count output.

Test Plan:
- Single segment, out_ready=1: one wr_seg_done. Required response:
  - 96 beats on 96 consecutive cycles, ordered (row0,b0..b3), (row1,b0..b3), ...
  - mem_addr runs 0..23, each held 4 clk.
  - out_last only on beat 96 (row 23, bank 3).
  - one seg_free pulse; credit returns to 0.
- Wrap: 5 segments written and read one at a time. Segment 4 reads addresses 72..95; segment 5 reads 0..23; seg_free pulses 5 times.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly. No duplicate or lost beats against a bank-content scoreboard; at most 2 issues outstanding beyond delivered beats; outputs stable while stalled.
- Credit edges:
  - wr_seg_done coincident with seg_free: credit unchanged.
  - 5 wr_seg_done with no reads: credit stays 4 and ovf_err=1 until reset; flush does not clear it.
- Pause: rd_enable low at row 10, bank 2 for 7 clk. Sequence resumes at row 10, bank 2, and the beat stream stays contiguous in order.
- Flush mid-READ at row 5: next clk out_valid=0, mem_cen_n=4'b1111. The next wr_seg_done starts reading at address 0, and no seg_free is issued for the aborted segment.
